// File: rtl/k_and_s_pkg.sv
// K&S multicycle processor shared definitions.
// Holds the decoded instruction enum, the 8-bit opcode constants,
// the 2-bit ALU operation encodings and the opcode decode helper.
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
    I_BRANCH, I_BZERO, I_BNEG, I_BNZERO, I_BNNEG, I_HALT
  } decoded_instruction_type;

  localparam logic [7:0] OP_LOAD   = 8'h81;
  localparam logic [7:0] OP_STORE  = 8'h82;
  localparam logic [7:0] OP_MOVE   = 8'h91;
  localparam logic [7:0] OP_ADD    = 8'hA1;
  localparam logic [7:0] OP_SUB    = 8'hA2;
  localparam logic [7:0] OP_AND    = 8'hA3;
  localparam logic [7:0] OP_OR     = 8'hA4;
  localparam logic [7:0] OP_BRANCH = 8'h01;
  localparam logic [7:0] OP_BZERO  = 8'h02;
  localparam logic [7:0] OP_BNEG   = 8'h03;
  localparam logic [7:0] OP_BNNEG  = 8'h04;
  localparam logic [7:0] OP_BNZERO = 8'h05;
  localparam logic [7:0] OP_HALT   = 8'hFF;

  localparam logic [1:0] ALU_OR  = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b11;

  // Unknown opcodes (including 8'h00) fall through to I_NOP.
  function automatic decoded_instruction_type decode_opcode(input logic [7:0] op);
    case (op)
      OP_LOAD:   return I_LOAD;
      OP_STORE:  return I_STORE;
      OP_MOVE:   return I_MOVE;
      OP_ADD:    return I_ADD;
      OP_SUB:    return I_SUB;
      OP_AND:    return I_AND;
      OP_OR:     return I_OR;
      OP_BRANCH: return I_BRANCH;
      OP_BZERO:  return I_BZERO;
      OP_BNEG:   return I_BNEG;
      OP_BNNEG:  return I_BNNEG;
      OP_BNZERO: return I_BNZERO;
      OP_HALT:   return I_HALT;
      default:   return I_NOP;
    endcase
  endfunction

endpackage

// File: rtl/ks_alu.sv
// Combinational 16-bit ALU of the K&S datapath.
// Ports: i_a, i_b operands; i_operation (OR/ADD/SUB/AND);
//        o_result; o_zero, o_neg, o_unsigned_overflow, o_signed_overflow.
module ks_alu
  import k_and_s_pkg::*;
(
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic [1:0]  i_operation,
  output logic [15:0] o_result,
  output logic        o_zero,
  output logic        o_neg,
  output logic        o_unsigned_overflow,
  output logic        o_signed_overflow
);

  logic [16:0] w_sum;
  logic [16:0] w_diff;

  // The 17th bit is the carry for ADD and the borrow (a < b) for SUB.
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_result            = 16'h0000;
    o_unsigned_overflow = 1'b0;
    o_signed_overflow   = 1'b0;
    case (i_operation)
      ALU_OR:  o_result = i_a | i_b;
      ALU_AND: o_result = i_a & i_b;
      ALU_ADD: begin
        o_result            = w_sum[15:0];
        o_unsigned_overflow = w_sum[16];
        o_signed_overflow   = (i_a[15] == i_b[15]) && (w_sum[15] != i_a[15]);
      end
      default: begin
        o_result            = w_diff[15:0];
        o_unsigned_overflow = w_diff[16];
        o_signed_overflow   = (i_a[15] != i_b[15]) && (w_diff[15] != i_a[15]);
      end
    endcase
  end

  assign o_zero = (o_result == 16'h0000);
  assign o_neg  = o_result[15];

endmodule

// File: rtl/datapath.sv
// K&S multicycle processor datapath: PC, IR, 4x16 register file, ALU and
// flag registers, driven by the control unit's per-cycle enables/selects.
// Inputs : clk, rst, branch, pc_enable, ir_enable, write_reg_enable,
//          addr_sel, c_sel, operation[1:0], flags_reg_enable, data_in[15:0].
// Outputs: decoded_instruction, zero_op, neg_op, unsigned_overflow,
//          signed_overflow (registered), ram_addr[4:0], data_out[15:0].
// There is no handshake: every enable takes effect on the edge it is high.
module datapath
  import k_and_s_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    write_reg_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic [1:0]              operation,
  input  logic                    flags_reg_enable,
  input  logic [15:0]             data_in,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic [4:0]              ram_addr,
  output logic [15:0]             data_out
);

  logic [4:0]  r_pc;
  logic [15:0] r_ir;
  logic [15:0] r_regs [0:3];

  decoded_instruction_type w_dec;
  logic [1:0]  w_a_idx, w_b_idx, w_c_idx;
  logic [15:0] w_a, w_b, w_c_data, w_result;
  logic        w_zero, w_neg, w_uovf, w_sovf;
  logic        w_unused;

  // IR bit 7 is not an operand field in any instruction format.
  assign w_unused = r_ir[7];

  assign w_dec               = decode_opcode(r_ir[15:8]);
  assign decoded_instruction = w_dec;

  always_comb begin
    w_a_idx = 2'd0;
    w_b_idx = 2'd0;
    w_c_idx = 2'd0;
    case (w_dec)
      // STORE also routes C to ir[6:5] so a same-cycle write hits the
      // register being stored.
      I_LOAD, I_STORE: begin
        w_a_idx = r_ir[6:5];
        w_c_idx = r_ir[6:5];
      end
      // MOVE reads the source on both ports; control issues OR.
      I_MOVE: begin
        w_c_idx = r_ir[3:2];
        w_a_idx = r_ir[1:0];
        w_b_idx = r_ir[1:0];
      end
      I_ADD, I_SUB, I_AND, I_OR: begin
        w_c_idx = r_ir[5:4];
        w_a_idx = r_ir[3:2];
        w_b_idx = r_ir[1:0];
      end
      default: ;
    endcase
  end

  // No write bypass: reads always see the pre-edge register contents.
  assign w_a      = r_regs[w_a_idx];
  assign w_b      = r_regs[w_b_idx];
  assign data_out = w_a;
  assign ram_addr = addr_sel ? r_ir[4:0] : r_pc;
  assign w_c_data = c_sel ? data_in : w_result;

  ks_alu u_alu (
    .i_a                 (w_a),
    .i_b                 (w_b),
    .i_operation         (operation),
    .o_result            (w_result),
    .o_zero              (w_zero),
    .o_neg               (w_neg),
    .o_unsigned_overflow (w_uovf),
    .o_signed_overflow   (w_sovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc              <= 5'd0;
      r_ir              <= 16'h0000;
      zero_op           <= 1'b0;
      neg_op            <= 1'b0;
      unsigned_overflow <= 1'b0;
      signed_overflow   <= 1'b0;
      for (int i = 0; i < 4; i++) r_regs[i] <= 16'h0000;
    end else begin
      // 5-bit PC wraps 31 -> 0 naturally.
      if (pc_enable)        r_pc <= branch ? r_ir[4:0] : r_pc + 5'd1;
      if (ir_enable)        r_ir <= data_in;
      if (write_reg_enable) r_regs[w_c_idx] <= w_c_data;
      if (flags_reg_enable) begin
        zero_op           <= w_zero;
        neg_op            <= w_neg;
        unsigned_overflow <= w_uovf;
        signed_overflow   <= w_sovf;
      end
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Directed testbench for the K&S datapath.
module tb_datapath;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic branch = 1'b0, pc_enable = 1'b0, ir_enable = 1'b0;
  logic write_reg_enable = 1'b0, addr_sel = 1'b0, c_sel = 1'b0;
  logic flags_reg_enable = 1'b0;
  logic [1:0]  operation = 2'b00;
  logic [15:0] data_in = 16'h0000;
  decoded_instruction_type decoded_instruction;
  logic zero_op, neg_op, unsigned_overflow, signed_overflow;
  logic [4:0]  ram_addr;
  logic [15:0] data_out;

  int total = 0;
  int bad   = 0;

  datapath dut (
    .clk(clk), .rst(rst), .branch(branch), .pc_enable(pc_enable),
    .ir_enable(ir_enable), .write_reg_enable(write_reg_enable),
    .addr_sel(addr_sel), .c_sel(c_sel), .operation(operation),
    .flags_reg_enable(flags_reg_enable), .data_in(data_in),
    .decoded_instruction(decoded_instruction), .zero_op(zero_op),
    .neg_op(neg_op), .unsigned_overflow(unsigned_overflow),
    .signed_overflow(signed_overflow), .ram_addr(ram_addr),
    .data_out(data_out)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; branch = 1'b0; pc_enable = 1'b0; ir_enable = 1'b0;
    write_reg_enable = 1'b0; addr_sel = 1'b0; c_sel = 1'b0;
    flags_reg_enable = 1'b0; operation = 2'b00;
  endtask

  task automatic load_ir(input logic [15:0] w);
    idle();
    data_in = w; ir_enable = 1'b1;
    tick();
    idle();
  endtask

  task automatic write_reg(input logic [1:0] r, input logic [15:0] v);
    load_ir(16'h8100 | (16'(r) << 5));
    data_in = v; c_sel = 1'b1; write_reg_enable = 1'b1;
    tick();
    idle();
  endtask

  // Executes one ALU instruction word with write-back and flag update.
  task automatic exec_alu(input logic [15:0] w, input logic [1:0] op);
    load_ir(w);
    operation = op; write_reg_enable = 1'b1; flags_reg_enable = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    for (int i = 0; i < 4; i++) begin
      branch = 1'($urandom_range(0, 1)); pc_enable = 1'($urandom_range(0, 1));
      ir_enable = 1'($urandom_range(0, 1)); write_reg_enable = 1'b1;
      c_sel = 1'b1; flags_reg_enable = 1'($urandom_range(0, 1));
      operation = 2'($urandom_range(0, 3)); data_in = 16'($urandom_range(1, 16'hFFFF));
      tick();
    end
    // Reset with every enable active must still win.
    rst = 1'b1; pc_enable = 1'b1; ir_enable = 1'b1; write_reg_enable = 1'b1;
    flags_reg_enable = 1'b1; data_in = 16'hA1FF;
    tick();
    idle();
    total++;
    if (decoded_instruction !== I_NOP) begin
      bad++; $display("FAIL reset_decode got=%0d exp=%0d", decoded_instruction, I_NOP);
    end
    total++;
    if (ram_addr !== 5'd0) begin
      bad++; $display("FAIL reset_pc got=%0d exp=0", ram_addr);
    end
    total++;
    if ({zero_op, neg_op, unsigned_overflow, signed_overflow} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000",
                      {zero_op, neg_op, unsigned_overflow, signed_overflow});
    end
    total++;
    if (data_out !== 16'h0000) begin
      bad++; $display("FAIL reset_data_out got=%h exp=0000", data_out);
    end
    for (int r = 0; r < 4; r++) begin
      load_ir(16'h8200 | 16'(r << 5));
      total++;
      if (data_out !== 16'h0000) begin
        bad++; $display("FAIL reset_reg%0d got=%h exp=0000", r, data_out);
      end
    end
    // IR loads above left PC untouched.
    total++;
    if (ram_addr !== 5'd0) begin
      bad++; $display("FAIL reset_pc_hold got=%0d exp=0", ram_addr);
    end
  endtask

  task automatic test_fetch();
    idle();
    data_in = 16'h8121; ir_enable = 1'b1; pc_enable = 1'b1;
    tick();
    idle();
    total++;
    if (decoded_instruction !== I_LOAD) begin
      bad++; $display("FAIL fetch_decode got=%0d exp=%0d", decoded_instruction, I_LOAD);
    end
    total++;
    if (ram_addr !== 5'd1) begin
      bad++; $display("FAIL fetch_pc got=%0d exp=1", ram_addr);
    end
    addr_sel = 1'b1;
    #1;
    total++;
    if (ram_addr !== 5'd1) begin
      bad++; $display("FAIL fetch_ir_addr got=%0d exp=1", ram_addr);
    end
    c_sel = 1'b1; write_reg_enable = 1'b1; data_in = 16'h1234;
    tick();
    idle();
    load_ir(16'h8220);
    total++;
    if (data_out !== 16'h1234) begin
      bad++; $display("FAIL fetch_load_r1 got=%h exp=1234", data_out);
    end
  endtask

  task automatic test_add_overflow();
    write_reg(2'd0, 16'h7FFF);
    write_reg(2'd1, 16'h0001);
    exec_alu(16'hA121, ALU_ADD);  // R2 = R0 + R1
    total++;
    if ({zero_op, neg_op, unsigned_overflow, signed_overflow} !== 4'b0101) begin
      bad++; $display("FAIL add_flags got=%b exp=0101",
                      {zero_op, neg_op, unsigned_overflow, signed_overflow});
    end
    load_ir(16'h8240);
    total++;
    if (data_out !== 16'h8000) begin
      bad++; $display("FAIL add_result got=%h exp=8000", data_out);
    end
    // Unsigned carry: 8000 + 8000 into R3, flags update.
    write_reg(2'd0, 16'h8000);
    exec_alu(16'hA130, ALU_ADD);  // R3 = R0 + R0
    total++;
    if ({zero_op, neg_op, unsigned_overflow, signed_overflow} !== 4'b1011) begin
      bad++; $display("FAIL add_carry_flags got=%b exp=1011",
                      {zero_op, neg_op, unsigned_overflow, signed_overflow});
    end
  endtask

  task automatic test_sub_borrow();
    write_reg(2'd0, 16'h0000);
    write_reg(2'd1, 16'h0001);
    exec_alu(16'hA231, ALU_SUB);  // R3 = R0 - R1
    total++;
    if ({zero_op, neg_op, unsigned_overflow, signed_overflow} !== 4'b0110) begin
      bad++; $display("FAIL sub_flags got=%b exp=0110",
                      {zero_op, neg_op, unsigned_overflow, signed_overflow});
    end
    load_ir(16'h8260);
    total++;
    if (data_out !== 16'hFFFF) begin
      bad++; $display("FAIL sub_result got=%h exp=ffff", data_out);
    end
    exec_alu(16'hA200, ALU_SUB);  // R0 = R0 - R0
    total++;
    if ({zero_op, neg_op, unsigned_overflow, signed_overflow} !== 4'b1000) begin
      bad++; $display("FAIL sub_zero_flags got=%b exp=1000",
                      {zero_op, neg_op, unsigned_overflow, signed_overflow});
    end
    // Signed overflow on SUB: 8000 - 0001 = 7FFF.
    write_reg(2'd0, 16'h8000);
    exec_alu(16'hA221, ALU_SUB);  // R2 = R0 - R1
    total++;
    if ({zero_op, neg_op, unsigned_overflow, signed_overflow} !== 4'b0001) begin
      bad++; $display("FAIL sub_sovf_flags got=%b exp=0001",
                      {zero_op, neg_op, unsigned_overflow, signed_overflow});
    end
    // Flags hold when flags_reg_enable is low.
    load_ir(16'hA231);
    operation = ALU_SUB; write_reg_enable = 1'b1;
    tick();
    idle();
    total++;
    if ({zero_op, neg_op, unsigned_overflow, signed_overflow} !== 4'b0001) begin
      bad++; $display("FAIL flags_hold got=%b exp=0001",
                      {zero_op, neg_op, unsigned_overflow, signed_overflow});
    end
  endtask

  task automatic test_logic_move();
    write_reg(2'd0, 16'hF0F0);
    write_reg(2'd1, 16'hFF00);
    exec_alu(16'hA321, ALU_AND);  // R2 = R0 & R1 = F000
    load_ir(16'h8240);
    total++;
    if (data_out !== 16'hF000) begin
      bad++; $display("FAIL and_result got=%h exp=f000", data_out);
    end
    exec_alu(16'hA431, ALU_OR);   // R3 = R0 | R1 = FFF0
    total++;
    if ({zero_op, neg_op, unsigned_overflow, signed_overflow} !== 4'b0100) begin
      bad++; $display("FAIL or_flags got=%b exp=0100",
                      {zero_op, neg_op, unsigned_overflow, signed_overflow});
    end
    exec_alu(16'h9107, ALU_OR);   // MOVE R1 <- R3
    load_ir(16'h8220);
    total++;
    if (data_out !== 16'hFFF0) begin
      bad++; $display("FAIL move_result got=%h exp=fff0", data_out);
    end
  endtask

  task automatic test_decode();
    logic [15:0] words [0:7];
    decoded_instruction_type exp [0:7];
    words = '{16'h0201, 16'h0301, 16'h0401, 16'h0501, 16'hFF00, 16'h0000, 16'h5500, 16'hA200};
    exp   = '{I_BZERO, I_BNEG, I_BNNEG, I_BNZERO, I_HALT, I_NOP, I_NOP, I_SUB};
    for (int i = 0; i < 8; i++) begin
      load_ir(words[i]);
      total++;
      if (decoded_instruction !== exp[i]) begin
        bad++; $display("FAIL decode_%h got=%0d exp=%0d", words[i], decoded_instruction, exp[i]);
      end
    end
  endtask

  task automatic test_branch_wrap();
    load_ir(16'h011F);
    total++;
    if (decoded_instruction !== I_BRANCH) begin
      bad++; $display("FAIL branch_decode got=%0d exp=%0d", decoded_instruction, I_BRANCH);
    end
    pc_enable = 1'b1; branch = 1'b1;
    tick();
    idle();
    total++;
    if (ram_addr !== 5'd31) begin
      bad++; $display("FAIL branch_to_31 got=%0d exp=31", ram_addr);
    end
    pc_enable = 1'b1;
    tick();
    idle();
    total++;
    if (ram_addr !== 5'd0) begin
      bad++; $display("FAIL pc_wrap got=%0d exp=0", ram_addr);
    end
    load_ir(16'h0107);
    pc_enable = 1'b1; branch = 1'b1;
    tick();
    idle();
    total++;
    if (ram_addr !== 5'd7) begin
      bad++; $display("FAIL branch_to_7 got=%0d exp=7", ram_addr);
    end
  endtask

  task automatic test_store_hazard();
    write_reg(2'd2, 16'hAAAA);
    load_ir(16'h8245);
    addr_sel = 1'b1;
    #1;
    total++;
    if (ram_addr !== 5'd5) begin
      bad++; $display("FAIL store_addr got=%0d exp=5", ram_addr);
    end
    c_sel = 1'b1; write_reg_enable = 1'b1; data_in = 16'h5555;
    #1;
    total++;
    if (data_out !== 16'hAAAA) begin
      bad++; $display("FAIL hazard_old got=%h exp=aaaa", data_out);
    end
    tick();
    idle();
    total++;
    if (data_out !== 16'h5555) begin
      bad++; $display("FAIL hazard_new got=%h exp=5555", data_out);
    end
  endtask

  initial begin
    idle();
    tick();
    test_reset();
    test_fetch();
    test_add_overflow();
    test_sub_borrow();
    test_logic_move();
    test_decode();
    test_branch_wrap();
    test_store_hazard();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/datapath.md
# datapath

Datapath of the K&S multicycle processor, the counterpart of the control unit. It holds the PC, instruction register, four-entry register file, ALU and flag registers. It obeys the control unit's per-cycle enables and selects, returns the decoded instruction and registered flags, and drives address and write data to the unified 32×16 RAM.

## Interface
Parameters: none. Widths are fixed by the ISA: 16-bit data, 5-bit address, 4 registers.

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- branch  in  1  1: PC loads ir[4:0] when pc_enable; 0: PC increments
- pc_enable  in  1  PC update strobe
- ir_enable  in  1  IR <= data_in
- write_reg_enable  in  1  register file write strobe
- addr_sel  in  1  ram_addr source: 1 = ir[4:0], 0 = PC
- c_sel  in  1  write-back source: 1 = data_in, 0 = ALU result
- operation  in  2  ALU op: 00 OR, 01 ADD, 10 SUB, 11 AND
- flags_reg_enable  in  1  flag registers <= ALU flags
- data_in  in  16  RAM read data
- decoded_instruction  out  decoded_instruction_type  decode of the current IR
- zero_op, neg_op, unsigned_overflow, signed_overflow  out  1 each  registered flags
- ram_addr  out  5  RAM address
- data_out  out  16  RAM write data, equal to register read port A

## Operation
- IR fields: opcode = ir[15:8].
  - LOAD 1000_0001: dest ir[6:5], addr ir[4:0].
  - STORE 1000_0010: src ir[6:5], addr ir[4:0].
  - MOVE 1001_0001: dest ir[3:2], src ir[1:0].
  - ADD/SUB/AND/OR 1010_0001/0010/0011/0100: dest ir[5:4], A ir[3:2], B ir[1:0].
  - BRANCH/BZERO/BNEG/BNZERO/BNNEG 0000_0001/0010/0011/0101/0100: target ir[4:0].
  - HALT 1111_1111.
  - Any other opcode, including 0000_0000, decodes to I_NOP.
- Register port mapping by decoded type:
  - LOAD: C = ir[6:5].
  - STORE: A = ir[6:5].
  - MOVE: C = ir[3:2], A = B = ir[1:0]. Control issues OR, so the result equals the source.
  - ALU ops: C/A/B as encoded above.
- ALU: 16-bit result.
  - ADD: unsigned_overflow = carry out of bit 15. signed_overflow = A and B share a sign and the result sign differs from it.
  - SUB (A−B): unsigned_overflow = borrow (A<B unsigned). signed_overflow = A and B signs differ and the result sign differs from A's sign.
  - OR/AND: both overflow flags 0.
  - All ops: zero = (result == 0), neg = result[15].
- PC: 5 bits. When pc_enable is high, PC <= branch ? ir[4:0] : PC+1, with 31 wrapping to 0.
- The register file has no write bypass. A read in the same cycle as a write to the same register returns the old value.
- decoded_instruction, ram_addr and data_out are combinational from current state and inputs. Flags change only on flags_reg_enable.

## Timing
- Reset, effective on the first rising edge with rst=1:
  - PC = 0, IR = 0 (decodes I_NOP), R0–R3 = 0, all flags 0.
  - With addr_sel=0, ram_addr = 0. data_out = 0.
  - rst overrides every enable in the same cycle. Reset mid-instruction discards all partial state.
- Fetch cycle (ir_enable=1, pc_enable=1, addr_sel=0):
  - IR captures the word at the old PC and PC increments, both on the same edge.
  - decoded_instruction is valid the cycle after.
- RAM read latency: data_in is valid combinationally in the same cycle as ram_addr, and is sampled at the edge.
- Flags written at edge N are visible to the control unit from cycle N+1. A branch decided in that cycle uses the new flags.
- Write-back and flag update are allowed on the same edge. Both use the same ALU result.
- No backpressure: every enable acts in the cycle it is asserted.

## Structure
- k_and_s_pkg holds decoded_instruction_type (I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_BRANCH, I_BZERO, I_BNEG, I_BNZERO, I_BNNEG, I_HALT), the opcode constants, and the operation encodings.
- There is one combinational sub-module, ks_alu: inputs A, B and operation; outputs result and the four flags. The register file, PC, IR and decode stay inline.

## Test plan
- Reset: assert rst for 1 cycle after random enables → PC=0, IR=0, decoded I_NOP, all flags 0, R0–R3 read 0.
- Fetch: RAM[0]=16'h8121, then fetch → IR=16'h8121, decoded I_LOAD, PC=1. Then addr_sel=1 → ram_addr=1. With c_sel=1, write_reg_enable=1 and data_in=16'h1234 → R1=16'h1234.
- ADD overflow: R0=16'h7FFF, R1=16'h0001, ADD dest R2 → R2=16'h8000, neg=1, signed_overflow=1, unsigned_overflow=0, zero=0.
- SUB borrow: R0=0, R1=1, SUB → result 16'hFFFF, unsigned_overflow=1, signed_overflow=0, neg=1. Then R0−R0 → zero=1.
- Branch/wrap: PC=31 with pc_enable, branch=0 → PC=0. IR=16'h0107 with branch=1 → PC=7.
- STORE and hazard: IR=16'h8245 → data_out=R2 and ram_addr=5 with addr_sel=1. A same-cycle write to R2 leaves data_out at the old value until the next cycle.
